bob_line_doubler: RTL and testbench

Avalon-ST video stage placed directly downstream of the pipe stage. It consumes an interlaced field stream (one packet per field) and emits a progressive frame packet containing every input line twice ("bob" line doubling). A single line buffer holds the current line. The block re-emits that line while holding off the input.

---
 rtl/bob_line_doubler.sv | 148 ++++++++++++++
 tb/tb_bob_line_doubler.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bob_line_doubler.sv
// bob_line_doubler
//   Bob deinterlacer for an Avalon-ST video stream. Each input field (one
//   packet) becomes one progressive output frame in which every input line
//   is emitted twice. The first copy of a line passes straight through the
//   output register while it is captured in a single line buffer. The second
//   copy is then replayed from that buffer while the input is held off.
//
// Ports
//   clock, reset        : single clock, synchronous active-high reset
//   din_*               : field input (readyLatency 0); din_endofpacket is
//                         ignored because framing comes from the counters
//   dout_*              : frame output (readyLatency 0), all registered
//   resync_err          : one-cycle pulse when a mid-field SOP restarts a field
module bob_line_doubler #(
  parameter int DATA_WIDTH      = 24,
  parameter int LINE_WIDTH      = 720,
  parameter int LINES_PER_FIELD = 288
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din_data,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic                  din_startofpacket,
  input  logic                  din_endofpacket,
  output logic [DATA_WIDTH-1:0] dout_data,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_startofpacket,
  output logic                  dout_endofpacket,
  output logic                  resync_err
);

  localparam int PIX_W = $clog2(LINE_WIDTH);
  localparam int LN_W  = (LINES_PER_FIELD > 1) ? $clog2(LINES_PER_FIELD) : 1;
  localparam logic [PIX_W-1:0] PIX_LAST  = PIX_W'(LINE_WIDTH - 1);
  localparam logic [LN_W-1:0]  LINE_LAST = LN_W'(LINES_PER_FIELD - 1);

  typedef enum logic [1:0] {
    WAIT_SOP,
    FILL,
    REPEAT
  } state_t;

  state_t                state;
  logic [PIX_W-1:0]      pix_cnt;
  logic [LN_W-1:0]       line_cnt;
  logic [DATA_WIDTH-1:0] line_buf [LINE_WIDTH];

  logic             free;
  logic             in_xfer;
  logic             sop_start;
  logic             pix_last;
  logic             line_last;
  logic [PIX_W-1:0] wr_idx;

  logic unused_eop;
  assign unused_eop = din_endofpacket;

  always_comb begin
    free      = !dout_valid || dout_ready;
    din_ready = !reset && free && (state != REPEAT);
    in_xfer   = din_valid && din_ready;
    pix_last  = (pix_cnt == PIX_LAST);
    line_last = (line_cnt == LINE_LAST);
    // An SOP starts a new field in WAIT_SOP, and also restarts one from FILL
    // unless FILL is sitting at the very first pixel of the field.
    sop_start = din_startofpacket &&
                ((state == WAIT_SOP) ||
                 ((state == FILL) && ((pix_cnt != '0) || (line_cnt != '0))));
    wr_idx    = sop_start ? '0 : pix_cnt;
  end

  always_ff @(posedge clock) begin
    if (in_xfer) begin
      line_buf[wr_idx] <= din_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state              <= WAIT_SOP;
      pix_cnt            <= '0;
      line_cnt           <= '0;
      dout_data          <= '0;
      dout_valid         <= 1'b0;
      dout_startofpacket <= 1'b0;
      dout_endofpacket   <= 1'b0;
      resync_err         <= 1'b0;
    end else begin
      resync_err <= 1'b0;
      // A free register with nothing new to load drains to invalid; any
      // load below overrides this.
      if (free) begin
        dout_valid <= 1'b0;
      end
      case (state)
        WAIT_SOP, FILL: begin
          if (in_xfer) begin
            if (sop_start) begin
              dout_data          <= din_data;
              dout_valid         <= 1'b1;
              dout_startofpacket <= 1'b1;
              dout_endofpacket   <= 1'b0;
              pix_cnt            <= PIX_W'(1);
              line_cnt           <= '0;
              resync_err         <= (state == FILL);
              state              <= FILL;
            end else if (state == FILL) begin
              dout_data          <= din_data;
              dout_valid         <= 1'b1;
              dout_startofpacket <= 1'b0;
              dout_endofpacket   <= 1'b0;
              if (pix_last) begin
                pix_cnt <= '0;
                state   <= REPEAT;
              end else begin
                pix_cnt <= pix_cnt + PIX_W'(1);
              end
            end
          end
        end
        REPEAT: begin
          if (free) begin
            dout_data          <= line_buf[pix_cnt];
            dout_valid         <= 1'b1;
            dout_startofpacket <= 1'b0;
            dout_endofpacket   <= pix_last && line_last;
            if (pix_last) begin
              pix_cnt <= '0;
              if (line_last) begin
                line_cnt <= '0;
                state    <= WAIT_SOP;
              end else begin
                line_cnt <= line_cnt + LN_W'(1);
                state    <= FILL;
              end
            end else begin
              pix_cnt <= pix_cnt + PIX_W'(1);
            end
          end
        end
        default: state <= WAIT_SOP;
      endcase
    end
  end

endmodule

// File: tb/tb_bob_line_doubler.sv
// tb_bob_line_doubler
//   Directed bench for bob_line_doubler with LINE_WIDTH=4, LINES_PER_FIELD=2.
//   Inputs change on the falling edge; outputs are observed there too.
module tb_bob_line_doubler;

  localparam int DW  = 24;
  localparam int LW  = 4;
  localparam int LPF = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic [DW-1:0] din_data;
  logic          din_valid;
  logic          din_ready;
  logic          din_startofpacket;
  logic          din_endofpacket;
  logic [DW-1:0] dout_data;
  logic          dout_valid;
  logic          dout_ready;
  logic          dout_startofpacket;
  logic          dout_endofpacket;
  logic          resync_err;

  always #5 clock = ~clock;

  bob_line_doubler #(
    .DATA_WIDTH      (DW),
    .LINE_WIDTH      (LW),
    .LINES_PER_FIELD (LPF)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .din_data           (din_data),
    .din_valid          (din_valid),
    .din_ready          (din_ready),
    .din_startofpacket  (din_startofpacket),
    .din_endofpacket    (din_endofpacket),
    .dout_data          (dout_data),
    .dout_valid         (dout_valid),
    .dout_ready         (dout_ready),
    .dout_startofpacket (dout_startofpacket),
    .dout_endofpacket   (dout_endofpacket),
    .resync_err         (resync_err)
  );

  int tests = 0;
  int fails = 0;

  // stimulus and expectations
  int            src[$];
  int            lit[$];
  logic [DW-1:0] in_d[$];
  logic          in_s[$];
  logic          in_e[$];
  bit            rdy_pat[$];
  logic [DW-1:0] exp_d[$];
  logic          exp_s[$];
  logic          exp_e[$];

  // observations
  logic [DW-1:0] od[$];
  logic          os[$];
  logic          oe[$];
  int            first_acc, first_out, last_out, ready_low, stab_viol, resync_cnt;
  bit            timeout;

  // Input beats from src; SOP on indices sa/sb, EOP on ea/eb (-1 = none).
  task automatic load_input(input int sa, input int sb, input int ea, input int eb);
    in_d.delete(); in_s.delete(); in_e.delete();
    foreach (src[k]) begin
      in_d.push_back(DW'(src[k]));
      in_s.push_back(k == sa || k == sb);
      in_e.push_back(k == ea || k == eb);
    end
  endtask

  // Expected output beats from lit; SOP on sa/sb, EOP on ea/eb (-1 = none).
  task automatic set_expect(input int sa, input int sb, input int ea, input int eb);
    exp_d.delete(); exp_s.delete(); exp_e.delete();
    foreach (lit[k]) begin
      exp_d.push_back(DW'(lit[k]));
      exp_s.push_back(k == sa || k == sb);
      exp_e.push_back(k == ea || k == eb);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; din_valid = 1'b0; din_startofpacket = 1'b0;
    din_endofpacket = 1'b0; din_data = '0; dout_ready = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // Streams in_d through the DUT until n_out output beats have been taken
  // and all input is consumed, or the cycle budget runs out.
  task automatic run_stream(input int n_out, input int budget);
    int            idx = 0;
    int            cyc = 0;
    bit            pstall = 1'b0;
    logic [DW-1:0] pd;
    logic          ps, pe;
    od.delete(); os.delete(); oe.delete();
    first_acc = -1; first_out = -1; last_out = -1;
    ready_low = 0; stab_viol = 0; resync_cnt = 0; timeout = 1'b0;
    pd = '0; ps = 1'b0; pe = 1'b0;
    forever begin
      @(negedge clock);
      if (pstall && (!dout_valid || dout_data !== pd ||
                     dout_startofpacket !== ps || dout_endofpacket !== pe))
        stab_viol++;
      if (resync_err) resync_cnt++;
      if (od.size() >= n_out && idx >= in_d.size()) break;
      if (cyc >= budget) begin timeout = 1'b1; break; end
      dout_ready        = rdy_pat[cyc % rdy_pat.size()];
      din_valid         = (idx < in_d.size());
      din_data          = din_valid ? in_d[idx] : '0;
      din_startofpacket = din_valid ? in_s[idx] : 1'b0;
      din_endofpacket   = din_valid ? in_e[idx] : 1'b0;
      if (dout_valid && dout_ready) begin
        od.push_back(dout_data); os.push_back(dout_startofpacket); oe.push_back(dout_endofpacket);
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
      end
      pstall = dout_valid && !dout_ready;
      pd = dout_data; ps = dout_startofpacket; pe = dout_endofpacket;
      #1;
      if (!din_ready) ready_low++;
      if (din_valid && din_ready) begin
        if (first_acc < 0) first_acc = cyc;
        idx++;
      end
      cyc++;
    end
    din_valid = 1'b0; din_startofpacket = 1'b0; din_endofpacket = 1'b0;
    dout_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; din_valid = 1'b0; din_startofpacket = 1'b0;
    din_endofpacket = 1'b0; din_data = '0; dout_ready = 1'b1;
    repeat (3) @(negedge clock);
    tests++; if (dout_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", dout_valid); end
    tests++; if (dout_data !== '0) begin fails++; $display("FAIL reset_data: got %0h expected 0", dout_data); end
    tests++; if (dout_startofpacket !== 1'b0) begin fails++; $display("FAIL reset_sop: got %b expected 0", dout_startofpacket); end
    tests++; if (dout_endofpacket !== 1'b0) begin fails++; $display("FAIL reset_eop: got %b expected 0", dout_endofpacket); end
    tests++; if (resync_err !== 1'b0) begin fails++; $display("FAIL reset_resync: got %b expected 0", resync_err); end
    tests++; if (din_ready !== 1'b0) begin fails++; $display("FAIL reset_din_ready: got %b expected 0", din_ready); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    src = '{1, 2, 3, 4, 5, 6, 7, 8};
    load_input(0, -1, 7, -1);
    lit = '{1, 2, 3, 4, 1, 2, 3, 4, 5, 6, 7, 8, 5, 6, 7, 8};
    set_expect(0, -1, 15, -1);
    rdy_pat = '{1'b1};
    run_stream(16, 200);
    tests++; if (timeout) begin fails++; $display("FAIL basic_timeout: got %0d beats expected 16", od.size()); end
    tests++; if (od.size() != exp_d.size()) begin fails++; $display("FAIL basic_count: got %0d expected %0d", od.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < od.size(); i++) begin
      tests++;
      if (od[i] !== exp_d[i] || os[i] !== exp_s[i] || oe[i] !== exp_e[i]) begin
        fails++;
        $display("FAIL basic_beat%0d: got data=%0h sop=%b eop=%b expected data=%0h sop=%b eop=%b",
                 i, od[i], os[i], oe[i], exp_d[i], exp_s[i], exp_e[i]);
      end
    end
    tests++; if (first_out != first_acc + 1) begin fails++; $display("FAIL basic_latency: got first out cycle %0d expected %0d", first_out, first_acc + 1); end
    tests++; if (last_out - first_out != 15) begin fails++; $display("FAIL basic_span: got %0d expected 15", last_out - first_out); end
    tests++; if (ready_low != 8) begin fails++; $display("FAIL basic_ready_low: got %0d expected 8", ready_low); end
  endtask

  task automatic test_backpressure();
    do_reset();
    src = '{1, 2, 3, 4, 5, 6, 7, 8};
    load_input(0, -1, 7, -1);
    lit = '{1, 2, 3, 4, 1, 2, 3, 4, 5, 6, 7, 8, 5, 6, 7, 8};
    set_expect(0, -1, 15, -1);
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    run_stream(16, 300);
    tests++; if (timeout) begin fails++; $display("FAIL bp_timeout: got %0d beats expected 16", od.size()); end
    tests++; if (od.size() != exp_d.size()) begin fails++; $display("FAIL bp_count: got %0d expected %0d", od.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < od.size(); i++) begin
      tests++;
      if (od[i] !== exp_d[i] || os[i] !== exp_s[i] || oe[i] !== exp_e[i]) begin
        fails++;
        $display("FAIL bp_beat%0d: got data=%0h sop=%b eop=%b expected data=%0h sop=%b eop=%b",
                 i, od[i], os[i], oe[i], exp_d[i], exp_s[i], exp_e[i]);
      end
    end
    tests++; if (stab_viol != 0) begin fails++; $display("FAIL bp_stable: got %0d stall changes expected 0", stab_viol); end
  endtask

  task automatic test_garbage();
    do_reset();
    src = '{'hEE, 'hEF, 'hF0, 1, 2, 3, 4, 5, 6, 7, 8};
    load_input(3, -1, 10, -1);
    lit = '{1, 2, 3, 4, 1, 2, 3, 4, 5, 6, 7, 8, 5, 6, 7, 8};
    set_expect(0, -1, 15, -1);
    rdy_pat = '{1'b1};
    run_stream(16, 200);
    tests++; if (timeout) begin fails++; $display("FAIL garbage_timeout: got %0d beats expected 16", od.size()); end
    tests++; if (od.size() != exp_d.size()) begin fails++; $display("FAIL garbage_count: got %0d expected %0d", od.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < od.size(); i++) begin
      tests++;
      if (od[i] !== exp_d[i] || os[i] !== exp_s[i] || oe[i] !== exp_e[i]) begin
        fails++;
        $display("FAIL garbage_beat%0d: got data=%0h sop=%b eop=%b expected data=%0h sop=%b eop=%b",
                 i, od[i], os[i], oe[i], exp_d[i], exp_s[i], exp_e[i]);
      end
    end
    tests++; if (first_out != first_acc + 4) begin fails++; $display("FAIL garbage_first_out: got cycle %0d expected %0d", first_out, first_acc + 4); end
    tests++; if (ready_low != 8) begin fails++; $display("FAIL garbage_ready_low: got %0d expected 8", ready_low); end
  endtask

  task automatic test_resync();
    do_reset();
    src = '{1, 2, 3, 4, 5, 6, 'hA0, 'hA1, 'hA2, 'hA3, 'hA4, 'hA5, 'hA6, 'hA7};
    load_input(0, 6, 13, -1);
    lit = '{1, 2, 3, 4, 1, 2, 3, 4, 5, 6,
            'hA0, 'hA1, 'hA2, 'hA3, 'hA0, 'hA1, 'hA2, 'hA3,
            'hA4, 'hA5, 'hA6, 'hA7, 'hA4, 'hA5, 'hA6, 'hA7};
    set_expect(0, 10, 25, -1);
    rdy_pat = '{1'b1};
    run_stream(26, 200);
    tests++; if (timeout) begin fails++; $display("FAIL resync_timeout: got %0d beats expected 26", od.size()); end
    tests++; if (od.size() != exp_d.size()) begin fails++; $display("FAIL resync_count: got %0d expected %0d", od.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < od.size(); i++) begin
      tests++;
      if (od[i] !== exp_d[i] || os[i] !== exp_s[i] || oe[i] !== exp_e[i]) begin
        fails++;
        $display("FAIL resync_beat%0d: got data=%0h sop=%b eop=%b expected data=%0h sop=%b eop=%b",
                 i, od[i], os[i], oe[i], exp_d[i], exp_s[i], exp_e[i]);
      end
    end
    tests++; if (resync_cnt != 1) begin fails++; $display("FAIL resync_pulse: got %0d cycles expected 1", resync_cnt); end
  endtask

  task automatic test_reset_mid_repeat();
    do_reset();
    src = '{1, 2, 3, 4};
    load_input(0, -1, -1, -1);
    rdy_pat = '{1'b1};
    // stop partway through the line-0 repeat (after 1,2,3,4,1,2)
    run_stream(6, 100);
    tests++; if (timeout) begin fails++; $display("FAIL midrst_timeout: got %0d beats expected 6", od.size()); end
    reset = 1'b1;
    @(negedge clock);
    tests++; if (dout_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid: got %b expected 0", dout_valid); end
    tests++; if (dout_data !== '0 || dout_startofpacket !== 1'b0 || dout_endofpacket !== 1'b0 || resync_err !== 1'b0) begin
      fails++;
      $display("FAIL midrst_outputs: got data=%0h sop=%b eop=%b resync=%b expected all 0",
               dout_data, dout_startofpacket, dout_endofpacket, resync_err);
    end
    reset = 1'b0;
    src = '{1, 2, 3, 4, 5, 6, 7, 8};
    load_input(0, -1, 7, -1);
    lit = '{1, 2, 3, 4, 1, 2, 3, 4, 5, 6, 7, 8, 5, 6, 7, 8};
    set_expect(0, -1, 15, -1);
    run_stream(16, 200);
    tests++; if (od.size() != exp_d.size()) begin fails++; $display("FAIL midrst_count: got %0d expected %0d", od.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < od.size(); i++) begin
      tests++;
      if (od[i] !== exp_d[i] || os[i] !== exp_s[i] || oe[i] !== exp_e[i]) begin
        fails++;
        $display("FAIL midrst_beat%0d: got data=%0h sop=%b eop=%b expected data=%0h sop=%b eop=%b",
                 i, od[i], os[i], oe[i], exp_d[i], exp_s[i], exp_e[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    src = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16};
    load_input(0, 8, 7, 15);
    lit = '{1, 2, 3, 4, 1, 2, 3, 4, 5, 6, 7, 8, 5, 6, 7, 8,
            9, 10, 11, 12, 9, 10, 11, 12, 13, 14, 15, 16, 13, 14, 15, 16};
    set_expect(0, 16, 15, 31);
    rdy_pat = '{1'b1};
    run_stream(32, 300);
    tests++; if (timeout) begin fails++; $display("FAIL b2b_timeout: got %0d beats expected 32", od.size()); end
    tests++; if (od.size() != exp_d.size()) begin fails++; $display("FAIL b2b_count: got %0d expected %0d", od.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < od.size(); i++) begin
      tests++;
      if (od[i] !== exp_d[i] || os[i] !== exp_s[i] || oe[i] !== exp_e[i]) begin
        fails++;
        $display("FAIL b2b_beat%0d: got data=%0h sop=%b eop=%b expected data=%0h sop=%b eop=%b",
                 i, od[i], os[i], oe[i], exp_d[i], exp_s[i], exp_e[i]);
      end
    end
    tests++; if (last_out - first_out != 31) begin fails++; $display("FAIL b2b_span: got %0d expected 31", last_out - first_out); end
    tests++; if (ready_low != 16) begin fails++; $display("FAIL b2b_ready_low: got %0d expected 16", ready_low); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_garbage();
    test_resync();
    test_reset_mid_repeat();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
